// File: rtl/sccb_init_ctrl.sv
// sccb_init_ctrl: walks a {reg_addr, data} table and issues one 3-phase SCCB write per entry
// Every SIO state is paced in quarter-bit slots; line values are precomputed from the next state and registered.
module sccb_init_ctrl #(
   parameter logic [7:0]  DEV_ID    = 8'h42,
   parameter int          QDIV      = 100,
   parameter logic [15:0] PWRUP_CYC = 16'd1000,
   parameter int          DLY_UNIT  = 1024,
   parameter int          TBL_AW    = 8
) (
   input  logic              cam_clk,
   input  logic              cam_reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [15:0]       tbl_data,
   output logic              sio_c,
   output logic              sio_d_oe,
   output logic              sio_d_o
);
   typedef enum logic [3:0] {IDLE, PWRUP, FETCH, START, BYTE, STOP, GAP, DELAY, ADV, FINISH} stateT;
   localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [31:0] DLY = DLY_UNIT;
   stateT state, stateNxt;
   logic [QW-1:0] qCnt, qCntNxt;
   logic [1:0] quarter, quarterNxt, phase, phaseNxt;
   logic [3:0] pos, posNxt;
   logic [31:0] cnt, cntNxt, pwrLoad, dlyLoad;
   logic [15:0] entry, entryNxt;
   logic [TBL_AW-1:0] addrNxt;
   logic sioCNxt, sioOeNxt, sioONxt, qEnd, bitEnd, sioState;

   // {sio_c, sio_d_oe, sio_d_o} for a given state and bit slot; idle lines are c=1, released
   function automatic logic [2:0] lines(stateT s, logic [1:0] q, logic [1:0] ph, logic [3:0] p, logic [15:0] e);
      logic [31:0] w;
      logic [4:0] idx;
      w = {DEV_ID, e, 8'h00};
      idx = 5'd31 - {ph, 3'b000} - {1'b0, p};
      return s == START ? {q != 2'd3, 1'b1, q < 2'd2} :
             s == BYTE  ? {q[1], p != 4'd8, (p == 4'd8) | w[idx]} :
             s == STOP  ? {q != 2'd0, q != 2'd3, q[1]} : 3'b101;
   endfunction

   assign busy = state != IDLE && state != FINISH;
   assign done = state == FINISH;
   assign qEnd = qCnt == QW'(QDIV - 1);
   assign bitEnd = qEnd && quarter == 2'd3;
   assign sioState = state == START || state == BYTE || state == STOP || state == GAP;
   assign pwrLoad = {16'd0, PWRUP_CYC} - 32'd1;
   assign dlyLoad = {24'd0, tbl_data[7:0]} * DLY - 32'd1;

   always_comb begin
      stateNxt = state;
      cntNxt = cnt;
      qCntNxt = sioState ? (qEnd ? '0 : qCnt + QW'(1)) : qCnt;
      quarterNxt = sioState && qEnd ? quarter + 2'd1 : quarter;
      phaseNxt = phase;
      posNxt = pos;
      entryNxt = entry;
      addrNxt = tbl_addr;
      case (state)
         IDLE: if (start) begin
            stateNxt = PWRUP;
            cntNxt = pwrLoad;
            addrNxt = '0;
         end
         PWRUP: begin
            cntNxt = cnt == 32'd0 ? 32'd1 : cnt - 32'd1;
            stateNxt = cnt == 32'd0 ? FETCH : PWRUP;
         end
         FETCH: if (cnt != 32'd0) cntNxt = cnt - 32'd1;
         else begin
            entryNxt = tbl_data;
            cntNxt = dlyLoad;
            qCntNxt = '0;
            quarterNxt = 2'd0;
            phaseNxt = 2'd0;
            posNxt = 4'd0;
            stateNxt = tbl_data == 16'hFFFF ? FINISH :
                       tbl_data[15:8] != 8'hFE ? START :
                       tbl_data[7:0] == 8'd0 ? ADV : DELAY;
         end
         START: if (bitEnd) stateNxt = BYTE;
         BYTE: if (bitEnd) begin
            posNxt = pos == 4'd8 ? 4'd0 : pos + 4'd1;
            phaseNxt = pos == 4'd8 ? phase + 2'd1 : phase;
            stateNxt = pos == 4'd8 && phase == 2'd2 ? STOP : BYTE;
         end
         STOP: if (bitEnd) stateNxt = GAP;
         GAP: if (bitEnd) stateNxt = ADV;
         DELAY: begin
            cntNxt = cnt - 32'd1;
            stateNxt = cnt == 32'd0 ? ADV : DELAY;
         end
         ADV: if (&tbl_addr) stateNxt = FINISH;
         else begin
            addrNxt = tbl_addr + TBL_AW'(1);
            cntNxt = 32'd1;
            stateNxt = FETCH;
         end
         FINISH: stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
      {sioCNxt, sioOeNxt, sioONxt} = lines(stateNxt, quarterNxt, phaseNxt, posNxt, entryNxt);
   end

   always_ff @(posedge cam_clk or negedge cam_reset_n) begin
      if (!cam_reset_n) begin
         state <= IDLE;
         cnt <= '0;
         qCnt <= '0;
         quarter <= '0;
         phase <= '0;
         pos <= '0;
         entry <= '0;
         tbl_addr <= '0;
         sio_c <= 1'b1;
         sio_d_oe <= 1'b0;
         sio_d_o <= 1'b1;
      end else begin
         state <= stateNxt;
         cnt <= cntNxt;
         qCnt <= qCntNxt;
         quarter <= quarterNxt;
         phase <= phaseNxt;
         pos <= posNxt;
         entry <= entryNxt;
         tbl_addr <= addrNxt;
         sio_c <= sioCNxt;
         sio_d_oe <= sioOeNxt;
         sio_d_o <= sioONxt;
      end
   end
endmodule

// File: tb/tb_sccb_init_ctrl.sv
// tb_sccb_init_ctrl: random register tables against a table-walk model; SIO bus decoded by a protocol monitor
module tb_sccb_init_ctrl;
   localparam int QDIV = 2;
   localparam int PWRUP = 4;
   localparam int DLY = 8;
   logic cam_clk = 1'b0, cam_reset_n = 1'b0, start = 1'b0;
   logic busy, done, sio_c, sio_d_oe, sio_d_o;
   logic [1:0] tbl_addr;
   logic [15:0] tbl_data;
   logic [15:0] rom [4];
   int total = 0, bad = 0, doneCnt = 0, activity = 0;

   sccb_init_ctrl #(.DEV_ID(8'h42), .QDIV(QDIV), .PWRUP_CYC(16'(PWRUP)), .DLY_UNIT(DLY), .TBL_AW(2)) dut (
      .cam_clk(cam_clk), .cam_reset_n(cam_reset_n), .start(start), .busy(busy), .done(done),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .sio_c(sio_c), .sio_d_oe(sio_d_oe), .sio_d_o(sio_d_o));

   always #5 cam_clk = ~cam_clk;
   always @(posedge cam_clk) tbl_data <= rom[tbl_addr];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // SCCB bus monitor: start/stop conditions, bits sampled on SIO_C rising, pull-up when released
   logic pc = 1'b1, psda = 1'b1, sda, inTx = 1'b0, hiValid = 1'b0;
   int nBits = 0, hiLen = 0;
   logic [27:0] bitsD, bitsOe;
   logic [23:0] monW;
   logic [26:0] om, eom;
   logic [23:0] gotQ [$];
   always @(negedge cam_clk) begin
      sda = sio_d_oe ? sio_d_o : 1'b1;
      if (!cam_reset_n) begin
         inTx = 1'b0;
         nBits = 0;
         hiValid = 1'b0;
      end else begin
         if (done) doneCnt++;
         if (!sio_c || sio_d_oe) activity++;
         if (sio_c && pc && psda && !sda) begin
            inTx = 1'b1;
            nBits = 0;
            hiValid = 1'b0;
         end else if (sio_c && pc && !psda && sda && inTx) begin
            inTx = 1'b0;
            checkVal("nbits", nBits, 28);
            for (int i = 0; i < 27; i++) begin
               om[i] = bitsOe[i];
               eom[i] = (i % 9) != 8;
            end
            checkVal("oe_mask", 32'(om), 32'(eom));
            for (int k = 0; k < 3; k++)
               for (int j = 0; j < 8; j++) monW = {monW[22:0], bitsD[9*k+j]};
            gotQ.push_back(monW);
         end else if (inTx && sio_c && !pc) begin
            if (nBits < 28) begin
               bitsD[nBits] = sda;
               bitsOe[nBits] = sio_d_oe;
            end
            nBits++;
            hiLen = 1;
            hiValid = 1'b1;
         end else if (inTx && sio_c && pc) hiLen++;
         else if (inTx && !sio_c && pc && hiValid) checkVal("c_high", hiLen, 2 * QDIV);
      end
      pc = sio_c;
      psda = sda;
   end

   task automatic runTable(input string tag, input bit noise);
      logic [23:0] expQ [$];
      int expCyc, a, cyc, d0;
      expCyc = PWRUP;
      a = 0;
      forever begin
         expCyc += 2;
         if (rom[a] == 16'hFFFF) break;
         if (rom[a][15:8] == 8'hFE) expCyc += int'(rom[a][7:0]) * DLY;
         else begin
            expQ.push_back({8'h42, rom[a]});
            expCyc += 120 * QDIV;
         end
         expCyc += 1;
         if (a == 3) break;
         a++;
      end
      gotQ.delete();
      activity = 0;
      d0 = doneCnt;
      @(negedge cam_clk) start = 1'b1;
      @(negedge cam_clk) start = 1'b0;
      checkVal({tag, "_busy_up"}, busy, 1);
      cyc = 1;
      while (busy && cyc < 5000) begin
         start = noise && ($urandom_range(0, 15) == 0);
         @(negedge cam_clk);
         if (busy) cyc++;
      end
      start = 1'b0;
      checkVal({tag, "_cycles"}, cyc, expCyc);
      checkVal({tag, "_done"}, done, 1);
      checkVal({tag, "_addr"}, tbl_addr, a);
      @(negedge cam_clk);
      checkVal({tag, "_done_low"}, done, 0);
      repeat (3) @(negedge cam_clk);
      checkVal({tag, "_done_cnt"}, doneCnt - d0, 1);
      checkVal({tag, "_activity"}, activity != 0, expQ.size() != 0);
      checkVal({tag, "_nwrites"}, gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) checkVal({tag, "_write"}, gotQ[i], expQ[i]);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rom[i] = 16'hFFFF;
      repeat (3) @(negedge cam_clk);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_done", done, 0);
      checkVal("rst_addr", tbl_addr, 0);
      checkVal("rst_sio_c", sio_c, 1);
      checkVal("rst_oe", sio_d_oe, 0);
      checkVal("rst_o", sio_d_o, 1);
      cam_reset_n = 1'b1;
      rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      runTable("t1", 1'b0);
      rom = '{16'hFE03, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      runTable("t2", 1'b0);
      rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      runTable("t3", 1'b1);
      rom = '{16'hFFFF, 16'h1111, 16'h2222, 16'h3333};
      runTable("t5", 1'b0);
      rom = '{16'h12A5, 16'h3C0F, 16'h7001, 16'hFD80};
      runTable("t6", 1'b0);
      @(negedge cam_clk) start = 1'b1;
      @(negedge cam_clk) start = 1'b0;
      repeat (30) @(negedge cam_clk);
      #2 cam_reset_n = 1'b0;
      #1;
      checkVal("t4_sio_c", sio_c, 1);
      checkVal("t4_oe", sio_d_oe, 0);
      checkVal("t4_busy", busy, 0);
      checkVal("t4_addr", tbl_addr, 0);
      @(negedge cam_clk) cam_reset_n = 1'b1;
      runTable("t4", 1'b0);
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 4; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rom[i] = r < 6 ? {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))} :
                     r < 8 ? {8'hFE, 8'($urandom_range(0, 4))} : 16'hFFFF;
         end
         runTable("rnd", 1'($urandom_range(0, 1)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
